// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN image streaming stages.
// Build option INPUT_OFFSET_EN: store pixels as (pix_data - 128) instead of raw bits.
package cnn_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIX_W = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } loader_state_t;

  // Subtracting 128 modulo 2^PIX_W is the same as flipping the sign bit.
  function automatic pixel_t to_pixel(input logic [PIX_W-1:0] raw);
`ifdef INPUT_OFFSET_EN
    to_pixel = pixel_t'(raw ^ {1'b1, {(PIX_W-1){1'b0}}});
`else
    to_pixel = pixel_t'(raw);
`endif
  endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// Raster row/column position counter with clear, increment and end-of-frame flag.
module pixel_addr_counter #(
  parameter int W     = 28,
  parameter int H     = 28,
  parameter int COL_W = $clog2(W),
  parameter int ROW_W = $clog2(H)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  // Clear has priority over increment; column wraps into the next row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc_i) begin
      if (col_q == COL_W'(W - 1)) begin
        col_q <= '0;
        row_q <= (row_q == ROW_W'(H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == ROW_W'(H - 1)) && (col_q == COL_W'(W - 1));

endmodule

// File: rtl/image_stream_loader.sv
// Streams a row-major frame into the CNN image array, then runs the CNN start/done handshake.
// Pixel storage format depends on INPUT_OFFSET_EN (see cnn_pkg::to_pixel).
module image_stream_loader
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic             pix_ready,
  output pixel_t           image [0:IMG_H-1][0:IMG_W-1],
  output logic             cnn_start,
  input  logic             cnn_done,
  input  logic [3:0]       cnn_class,
  output logic             result_valid,
  output logic [3:0]       result_class,
  output logic             frame_err,
  output logic             busy
);

  loader_state_t    state_q;
  logic             pix_ready_q;
  logic             cnn_start_q;
  logic             done_q;
  logic             result_valid_q;
  logic [3:0]       result_class_q;
  logic             frame_err_q;
  pixel_t           image_q [0:IMG_H-1][0:IMG_W-1];

  logic             accept_s;
  logic             last_pos_s;
  logic             cnt_inc_s;
  logic             cnt_clr_s;
  logic [ROW_W-1:0] row_s;
  logic [COL_W-1:0] col_s;

  assign accept_s  = pix_valid && pix_ready_q && (state_q == LOAD);
  // Any pix_last or end-of-frame position ends the frame, good or bad.
  assign cnt_inc_s = accept_s && !pix_last && !last_pos_s;
  assign cnt_clr_s = (accept_s && (pix_last || last_pos_s)) || (state_q == RELEASE);

  pixel_addr_counter #(
    .W (IMG_W),
    .H (IMG_H)
  ) u_addr (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (cnt_clr_s),
    .inc_i  (cnt_inc_s),
    .row_o  (row_s),
    .col_o  (col_s),
    .last_o (last_pos_s)
  );

  // Frame buffer: written only by accepted pixels in LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < IMG_H; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          image_q[r][c] <= '0;
        end
      end
    end else if (accept_s) begin
      image_q[row_s][col_s] <= to_pixel(pix_data);
    end
  end

  // Loader sequencing; done_q tracks cnn_done every cycle so it is pre-loaded before WAIT_DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= LOAD;
      pix_ready_q    <= 1'b0;
      cnn_start_q    <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= 4'd0;
      frame_err_q    <= 1'b0;
    end else begin
      done_q         <= cnn_done;
      result_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      case (state_q)
        LOAD: begin
          pix_ready_q <= 1'b1;
          if (accept_s) begin
            if (pix_last && last_pos_s) begin
              state_q     <= START;
              cnn_start_q <= 1'b1;
              pix_ready_q <= 1'b0;
            end else if (pix_last != last_pos_s) begin
              frame_err_q <= 1'b1;
            end
          end
        end
        START: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (cnn_done && !done_q) begin
            result_class_q <= cnn_class;
            result_valid_q <= 1'b1;
            cnn_start_q    <= 1'b0;
            state_q        <= RELEASE;
          end
        end
        RELEASE: begin
          state_q     <= LOAD;
          pix_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= LOAD;
          pix_ready_q <= 1'b0;
          cnn_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready    = pix_ready_q;
  assign cnn_start    = cnn_start_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != LOAD);
  assign image        = image_q;

endmodule

// File: doc/image_stream_loader.md
Name: image_stream_loader

Overview:
Upstream feeder for the CNN inference top. Accepts a row-major 28x28 pixel stream over a valid/ready handshake and assembles it into the image array the CNN reads. It then drives the CNN start/done handshake and latches the predicted class. It replaces the static file-based image load, so frames can be streamed back-to-back from a host or DMA.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
PIX_W, 8, pixel width; stored signed

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  asynchronous active-low reset (asserted when 0)
pix_valid  in  1  pixel present on pix_data
pix_data  in  PIX_W  pixel value
pix_last  in  1  marks final pixel of frame
pix_ready  out  1  loader accepts pixel this cycle
image  out  signed PIX_W x [0:IMG_H-1][0:IMG_W-1]  assembled frame to CNN input_image
cnn_start  out  1  level start to CNN top
cnn_done  in  1  CNN done level (sticky high once set)
cnn_class  in  4  CNN predicted_class
result_valid  out  1  one-cycle pulse, new result
result_class  out  4  latched class of last completed frame
frame_err  out  1  one-cycle pulse, framing error, frame dropped
busy  out  1  high outside LOAD state

Behaviour:
- Reset (reset=0, async): state=LOAD, pix_cnt=0, image all 0, pix_ready=0 in reset then 1, cnn_start=0, result_valid=0, result_class=0, frame_err=0, done_q=0.
- Pixel accepted when pix_valid & pix_ready. Write image[pix_cnt/IMG_W][pix_cnt%IMG_W] using row/col counters, no divider; col wraps at IMG_W-1, row increments.
- FSM states: LOAD, START, WAIT_DONE, RELEASE.
- LOAD: pix_ready=1. On an accepted pixel with count N=IMG_W*IMG_H-1 and pix_last=1: write it, go START next cycle.
- LOAD framing errors: pix_last=1 at count<N, or pix_last=0 at count N. Either one pulses frame_err, resets the counters to 0, stays in LOAD. Already-written pixels are left as stale data and are overwritten by the next frame.
- START: cnn_start=1, pix_ready=0. Go WAIT_DONE next cycle.
- WAIT_DONE: cnn_start held 1. done_q registers cnn_done. A rising edge (cnn_done & !done_q) latches result_class<=cnn_class, pulses result_valid, and moves to RELEASE. The loader does not rely on cnn_done falling; it is sticky in the CNN.
- cnn_done already high on WAIT_DONE entry (previous frame): no edge, so no false completion. done_q is pre-loaded to cnn_done on the START cycle.
- RELEASE: cnn_start=0 for one cycle so the CNN returns to IDLE, then go to LOAD with counters at 0.
- image is stable (not written) in START/WAIT_DONE/RELEASE. pix_ready=0 in those states blocks writes.
- busy = (state != LOAD).
- Latency: START is entered 1 cycle after the last pixel handshake; result_valid comes 1 cycle after the cnn_done rise; pix_ready returns 2 cycles after the cnn_done rise.
- Reset mid-operation: everything returns to reset values immediately and the partial frame is discarded.

Optional Feature:
Macro INPUT_OFFSET_EN.
- Defined: pix_data is unsigned 0..255; the stored value is pix_data-128 as signed PIX_W (0->-128, 255->127, 128->0).
- Undefined: pix_data is stored bit-for-bit as signed PIX_W (0x80 -> -128).

Decomposition:
- Shared package cnn_pkg: IMG_W/IMG_H/PIX_W constants, loader_state_t enum, pixel_t typedef (logic signed [PIX_W-1:0]).
- One sub-module, pixel_addr_counter: row/col counter with increment, clear and last-position flag. Reused by other streaming stages.

Test Plan:
- Full frame, pixel k = k mod 256, INPUT_OFFSET_EN off: 784 handshakes with last on #783 -> image[0][5]=5, image[9][4]=(256 mod 256)=0, image[27][27]=(783 mod 256)=15 as signed; cnn_start rises 1 cycle after the last handshake.
- Drive cnn_done high 50 cycles after start with cnn_class=7 -> result_valid one-cycle pulse, result_class=7; cnn_start low one cycle; pix_ready=1 two cycles after the done rise.
- Second frame with cnn_done still stuck high from frame 1 -> no result until cnn_done drops and re-rises; class 3 on the re-rise is latched.
- pix_last on pixel #100 -> frame_err pulse, state LOAD, next 784-pixel frame loads correctly from image[0][0].
- Random pix_valid gaps, INPUT_OFFSET_EN on, pixel value 0 -> stored -128; value 200 -> 72; no pixel accepted while busy=1.
- reset=0 asserted mid-WAIT_DONE -> cnn_start=0 and result_class=0 with no clock edge; after release, pix_ready=1 and a new frame is accepted.
